// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command dispatcher.
// Covers the word width, the null command encoding and the dispatcher FSM states.
package uart_cmd_pkg;

   localparam int CMD_W = 16;

   localparam logic [CMD_W-1:0] NULL_CMD = 16'h0000;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CLEAR    = 2'd1,
      WAIT_LOW = 2'd2
   } dispatch_state_t;

endpackage : uart_cmd_pkg

// File: rtl/uart_cmd_dispatch_cmd_fifo.sv
// First-word-fall-through command queue with a registered head and registered empty/full flags.
// Pointers carry one extra wrap bit, so full and empty come from comparing the MSBs.
module cmd_fifo
   import uart_cmd_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CMD_W      = uart_cmd_pkg::CMD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [CMD_W-1:0] push_data,
   input  logic             pop,
   output logic [CMD_W-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [CMD_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             r_empty;
   logic             r_full;
   logic [CMD_W-1:0] r_head;

   logic             w_do_push;
   logic             w_do_pop;
   logic [AW:0]      w_wr_nxt;
   logic [AW:0]      w_rd_nxt;
   logic             w_empty_nxt;
   logic             w_full_nxt;
   logic [CMD_W-1:0] w_head_nxt;

   // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      w_do_push   = push && !r_full;
      w_do_pop    = pop && !r_empty;
      w_wr_nxt    = r_wr_ptr + (AW+1)'(w_do_push);
      w_rd_nxt    = r_rd_ptr + (AW+1)'(w_do_pop);
      w_empty_nxt = (w_wr_nxt == w_rd_nxt);
      w_full_nxt  = (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                    (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
      w_head_nxt  = r_mem[w_rd_nxt[AW-1:0]];
      // The word being written this cycle becomes the head when nothing older remains ahead of it.
      if (w_do_push && (w_rd_nxt[AW-1:0] == r_wr_ptr[AW-1:0])) begin
         w_head_nxt = push_data;
      end
      if (w_empty_nxt) begin
         w_head_nxt = '0;
      end
   end

   // NOTE: the storage array has no reset; the pointers and flags alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_head   <= '0;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;
         r_empty  <= w_empty_nxt;
         r_full   <= w_full_nxt;
         r_head   <= w_head_nxt;
      end
   end

   assign head  = r_head;
   assign empty = r_empty;
   assign full  = r_full;

endmodule : cmd_fifo

// File: rtl/uart_cmd_dispatch.sv
// Routes the interpreter's held MGU/GNU snapshot into per-unit queues and returns a one-cycle cmd_clear.
// Optional statistics counters are built when UART_CMD_DISPATCH_STATS_EN is defined.
module uart_cmd_dispatch
   import uart_cmd_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CMD_W      = uart_cmd_pkg::CMD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_set,
   input  logic [CMD_W-1:0] mgu_cmd,
   input  logic [CMD_W-1:0] gnu_cmd,
   output logic             cmd_clear,
   output logic             mgu_valid,
   output logic [CMD_W-1:0] mgu_data,
   input  logic             mgu_ready,
   output logic             gnu_valid,
   output logic [CMD_W-1:0] gnu_data,
   input  logic             gnu_ready
`ifdef UART_CMD_DISPATCH_STATS_EN
   ,
   output logic [15:0]      stat_accepted,
   output logic [15:0]      stat_stall
`endif
);

   dispatch_state_t r_state;
   dispatch_state_t w_state_nxt;
   logic            r_cmd_clear;

   logic             w_mgu_hit;
   logic             w_gnu_hit;
   logic             w_accept;
   logic             w_stall;
   logic             w_mgu_push;
   logic             w_gnu_push;
   logic             w_mgu_empty;
   logic             w_mgu_full;
   logic             w_gnu_empty;
   logic             w_gnu_full;
   logic [CMD_W-1:0] w_mgu_head;
   logic [CMD_W-1:0] w_gnu_head;

   assign w_mgu_hit  = (mgu_cmd != CMD_W'(NULL_CMD));
   assign w_gnu_hit  = (gnu_cmd != CMD_W'(NULL_CMD));
   assign w_mgu_push = w_accept && w_mgu_hit;
   assign w_gnu_push = w_accept && w_gnu_hit;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         IDLE: begin
            if (cmd_set) begin
               // A null word never needs space, so only targeted queues can stall the snapshot.
               if (!(w_mgu_hit && w_mgu_full) && !(w_gnu_hit && w_gnu_full)) begin
                  w_accept    = 1'b1;
                  w_state_nxt = CLEAR;
               end else begin
                  w_stall = 1'b1;
               end
            end
         end
         CLEAR:    w_state_nxt = WAIT_LOW;
         WAIT_LOW: if (!cmd_set) w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cmd_clear <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cmd_clear <= w_accept;
      end
   end

   cmd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CMD_W      (CMD_W)
   ) u_mgu_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_mgu_push),
      .push_data (mgu_cmd),
      .pop       (mgu_ready),
      .head      (w_mgu_head),
      .empty     (w_mgu_empty),
      .full      (w_mgu_full)
   );

   cmd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CMD_W      (CMD_W)
   ) u_gnu_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_gnu_push),
      .push_data (gnu_cmd),
      .pop       (gnu_ready),
      .head      (w_gnu_head),
      .empty     (w_gnu_empty),
      .full      (w_gnu_full)
   );

   assign cmd_clear = r_cmd_clear;
   assign mgu_valid = !w_mgu_empty;
   assign mgu_data  = w_mgu_head;
   assign gnu_valid = !w_gnu_empty;
   assign gnu_data  = w_gnu_head;

`ifdef UART_CMD_DISPATCH_STATS_EN
   logic [15:0] r_stat_accepted;
   logic [15:0] r_stat_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_accepted <= '0;
         r_stat_stall    <= '0;
      end else begin
         if (w_accept && (r_stat_accepted != 16'hFFFF)) begin
            r_stat_accepted <= r_stat_accepted + 16'd1;
         end
         if (w_stall && (r_stat_stall != 16'hFFFF)) begin
            r_stat_stall <= r_stat_stall + 16'd1;
         end
      end
   end

   assign stat_accepted = r_stat_accepted;
   assign stat_stall    = r_stat_stall;
`endif

endmodule : uart_cmd_dispatch

// File: tb/tb_uart_cmd_dispatch.sv
// Directed self-checking bench for uart_cmd_dispatch at FIFO_DEPTH=4, CMD_W=16.
// Statistics checks are compiled in only when UART_CMD_DISPATCH_STATS_EN is defined.
module tb_uart_cmd_dispatch;

   logic        clk;
   logic        rst;
   logic        cmd_set;
   logic [15:0] mgu_cmd;
   logic [15:0] gnu_cmd;
   logic        cmd_clear;
   logic        mgu_valid;
   logic [15:0] mgu_data;
   logic        mgu_ready;
   logic        gnu_valid;
   logic [15:0] gnu_data;
   logic        gnu_ready;
`ifdef UART_CMD_DISPATCH_STATS_EN
   logic [15:0] stat_accepted;
   logic [15:0] stat_stall;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int clear_cnt = 0;

   uart_cmd_dispatch #(
      .FIFO_DEPTH (4),
      .CMD_W      (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_set       (cmd_set),
      .mgu_cmd       (mgu_cmd),
      .gnu_cmd       (gnu_cmd),
      .cmd_clear     (cmd_clear),
      .mgu_valid     (mgu_valid),
      .mgu_data      (mgu_data),
      .mgu_ready     (mgu_ready),
      .gnu_valid     (gnu_valid),
      .gnu_data      (gnu_data),
      .gnu_ready     (gnu_ready)
`ifdef UART_CMD_DISPATCH_STATS_EN
      ,
      .stat_accepted (stat_accepted),
      .stat_stall    (stat_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts cycles with cmd_clear high, sampled mid-cycle.
   always @(negedge clk) begin
      if (cmd_clear === 1'b1) clear_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic snap(input logic [15:0] m, input logic [15:0] g);
      mgu_cmd = m;
      gnu_cmd = g;
      cmd_set = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_set = 1'b0; mgu_cmd = '0; gnu_cmd = '0;
      mgu_ready = 1'b0; gnu_ready = 1'b0;
      step(); step();
      n_checks++; if (cmd_clear !== 1'b0) begin n_fail++; $display("FAIL reset_clear: got %b want 0", cmd_clear); end
      n_checks++; if (mgu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mgu_valid: got %b want 0", mgu_valid); end
      n_checks++; if (gnu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gnu_valid: got %b want 0", gnu_valid); end
      n_checks++; if (mgu_data !== 16'h0000) begin n_fail++; $display("FAIL reset_mgu_data: got %h want 0000", mgu_data); end
      n_checks++; if (gnu_data !== 16'h0000) begin n_fail++; $display("FAIL reset_gnu_data: got %h want 0000", gnu_data); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_mgu_only();
      int c0;
      c0 = clear_cnt;
      snap(16'hF128, 16'h0000);
      step();
      n_checks++; if (mgu_valid !== 1'b1) begin n_fail++; $display("FAIL t1_mgu_valid: got %b want 1", mgu_valid); end
      n_checks++; if (mgu_data !== 16'hF128) begin n_fail++; $display("FAIL t1_mgu_data: got %h want f128", mgu_data); end
      n_checks++; if (gnu_valid !== 1'b0) begin n_fail++; $display("FAIL t1_gnu_valid: got %b want 0", gnu_valid); end
      n_checks++; if (cmd_clear !== 1'b1) begin n_fail++; $display("FAIL t1_clear_hi: got %b want 1", cmd_clear); end
      cmd_set = 1'b0;
      step();
      n_checks++; if (cmd_clear !== 1'b0) begin n_fail++; $display("FAIL t1_clear_lo: got %b want 0", cmd_clear); end
      step();
      n_checks++; if (clear_cnt - c0 !== 1) begin n_fail++; $display("FAIL t1_clear_pulses: got %0d want 1", clear_cnt - c0); end
      mgu_ready = 1'b1; step(); mgu_ready = 1'b0;
      n_checks++; if (mgu_valid !== 1'b0) begin n_fail++; $display("FAIL t1_drained: got %b want 0", mgu_valid); end
      // ready on an empty queue must not move anything
      mgu_ready = 1'b1; gnu_ready = 1'b1; step(); mgu_ready = 1'b0; gnu_ready = 1'b0;
   endtask

   task automatic test_dual();
      int c0;
      c0 = clear_cnt;
      snap(16'hF128, 16'h0A05);
      step();
      n_checks++; if (mgu_valid !== 1'b1 || mgu_data !== 16'hF128) begin n_fail++; $display("FAIL t2_mgu: got %b/%h want 1/f128", mgu_valid, mgu_data); end
      n_checks++; if (gnu_valid !== 1'b1 || gnu_data !== 16'h0A05) begin n_fail++; $display("FAIL t2_gnu: got %b/%h want 1/0a05", gnu_valid, gnu_data); end
      cmd_set = 1'b0;
      step(); step();
      n_checks++; if (clear_cnt - c0 !== 1) begin n_fail++; $display("FAIL t2_clear_pulses: got %0d want 1", clear_cnt - c0); end
      mgu_ready = 1'b1; gnu_ready = 1'b1; step(); mgu_ready = 1'b0; gnu_ready = 1'b0;
      n_checks++; if (mgu_valid !== 1'b0 || gnu_valid !== 1'b0) begin n_fail++; $display("FAIL t2_drained: got %b%b want 00", mgu_valid, gnu_valid); end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp;
      for (int i = 0; i < 4; i++) begin
         snap(16'h00F0 + 16'(i), 16'h0000);
         step();
         n_checks++; if (cmd_clear !== 1'b1) begin n_fail++; $display("FAIL t3_fill_clear%0d: got %b want 1", i, cmd_clear); end
         cmd_set = 1'b0;
         step(); step();
      end
      n_checks++; if (mgu_data !== 16'h00F0) begin n_fail++; $display("FAIL t3_head_full: got %h want 00f0", mgu_data); end
      snap(16'h00F4, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (cmd_clear !== 1'b0) begin n_fail++; $display("FAIL t3_stall%0d: got %b want 0", i, cmd_clear); end
      end
      mgu_ready = 1'b1; step(); mgu_ready = 1'b0;
      n_checks++; if (cmd_clear !== 1'b0) begin n_fail++; $display("FAIL t3_no_pushthrough: got %b want 0", cmd_clear); end
      n_checks++; if (mgu_data !== 16'h00F1) begin n_fail++; $display("FAIL t3_head_after_pop: got %h want 00f1", mgu_data); end
      step();
      n_checks++; if (cmd_clear !== 1'b1) begin n_fail++; $display("FAIL t3_fifth_clear: got %b want 1", cmd_clear); end
      cmd_set = 1'b0;
      step(); step();
      for (int i = 1; i < 5; i++) begin
         exp = 16'h00F0 + 16'(i);
         n_checks++; if (mgu_valid !== 1'b1 || mgu_data !== exp) begin n_fail++; $display("FAIL t3_order%0d: got %b/%h want 1/%h", i, mgu_valid, mgu_data, exp); end
         mgu_ready = 1'b1; step(); mgu_ready = 1'b0;
      end
      n_checks++; if (mgu_valid !== 1'b0) begin n_fail++; $display("FAIL t3_drained: got %b want 0", mgu_valid); end
   endtask

   task automatic test_hold();
      int c0;
      c0 = clear_cnt;
      snap(16'h1234, 16'h0000);
      step();
      n_checks++; if (cmd_clear !== 1'b1) begin n_fail++; $display("FAIL t4_clear: got %b want 1", cmd_clear); end
      repeat (10) step();
      n_checks++; if (clear_cnt - c0 !== 1) begin n_fail++; $display("FAIL t4_single_clear: got %0d want 1", clear_cnt - c0); end
      cmd_set = 1'b0;
      step();
      snap(16'h5678, 16'h0000);
      step();
      n_checks++; if (cmd_clear !== 1'b1) begin n_fail++; $display("FAIL t4_rearm: got %b want 1", cmd_clear); end
      cmd_set = 1'b0;
      step(); step();
      n_checks++; if (mgu_data !== 16'h1234) begin n_fail++; $display("FAIL t4_first: got %h want 1234", mgu_data); end
      mgu_ready = 1'b1; step(); mgu_ready = 1'b0;
      n_checks++; if (mgu_valid !== 1'b1 || mgu_data !== 16'h5678) begin n_fail++; $display("FAIL t4_second: got %b/%h want 1/5678", mgu_valid, mgu_data); end
      mgu_ready = 1'b1; step(); mgu_ready = 1'b0;
      n_checks++; if (mgu_valid !== 1'b0) begin n_fail++; $display("FAIL t4_drained: got %b want 0", mgu_valid); end
   endtask

   task automatic test_null();
      snap(16'h0000, 16'h0000);
      step();
      n_checks++; if (cmd_clear !== 1'b1) begin n_fail++; $display("FAIL t5_clear: got %b want 1", cmd_clear); end
      n_checks++; if (mgu_valid !== 1'b0 || gnu_valid !== 1'b0) begin n_fail++; $display("FAIL t5_no_valid: got %b%b want 00", mgu_valid, gnu_valid); end
      cmd_set = 1'b0;
      step(); step();
   endtask

   task automatic test_back_to_back();
      snap(16'hAAAA, 16'h0000);
      step();
      cmd_set = 1'b0;
      step(); step();
      snap(16'hBBBB, 16'h0000);
      mgu_ready = 1'b1;
      step();
      mgu_ready = 1'b0;
      n_checks++; if (cmd_clear !== 1'b1) begin n_fail++; $display("FAIL b2b_clear: got %b want 1", cmd_clear); end
      n_checks++; if (mgu_valid !== 1'b1 || mgu_data !== 16'hBBBB) begin n_fail++; $display("FAIL b2b_head: got %b/%h want 1/bbbb", mgu_valid, mgu_data); end
      cmd_set = 1'b0;
      step(); step();
      mgu_ready = 1'b1; step(); mgu_ready = 1'b0;
      n_checks++; if (mgu_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_count: got %b want 0", mgu_valid); end
   endtask

   task automatic test_stats();
`ifdef UART_CMD_DISPATCH_STATS_EN
      n_checks++; if (stat_accepted !== 16'd12) begin n_fail++; $display("FAIL stat_accepted: got %0d want 12", stat_accepted); end
      n_checks++; if (stat_stall !== 16'd4) begin n_fail++; $display("FAIL stat_stall: got %0d want 4", stat_stall); end
`endif
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         snap(16'h1111 + 16'(i), 16'h2222 + 16'(i));
         step();
         cmd_set = 1'b0;
         step(); step();
      end
      n_checks++; if (mgu_valid !== 1'b1 || gnu_valid !== 1'b1) begin n_fail++; $display("FAIL t6_loaded: got %b%b want 11", mgu_valid, gnu_valid); end
      snap(16'h7777, 16'h0000);
      rst = 1'b1;
      step();
      n_checks++; if (mgu_valid !== 1'b0 || gnu_valid !== 1'b0) begin n_fail++; $display("FAIL t6_flushed: got %b%b want 00", mgu_valid, gnu_valid); end
      n_checks++; if (cmd_clear !== 1'b0) begin n_fail++; $display("FAIL t6_clear: got %b want 0", cmd_clear); end
      step();
      rst = 1'b0;
      step();
      n_checks++; if (cmd_clear !== 1'b1 || mgu_data !== 16'h7777) begin n_fail++; $display("FAIL t6_recapture: got %b/%h want 1/7777", cmd_clear, mgu_data); end
      n_checks++; if (gnu_valid !== 1'b0) begin n_fail++; $display("FAIL t6_gnu: got %b want 0", gnu_valid); end
`ifdef UART_CMD_DISPATCH_STATS_EN
      n_checks++; if (stat_accepted !== 16'd1 || stat_stall !== 16'd0) begin n_fail++; $display("FAIL t6_stats: got %0d/%0d want 1/0", stat_accepted, stat_stall); end
`endif
      cmd_set = 1'b0;
      step(); step();
      mgu_ready = 1'b1; step(); mgu_ready = 1'b0;
      n_checks++; if (mgu_valid !== 1'b0) begin n_fail++; $display("FAIL t6_drained: got %b want 0", mgu_valid); end
   endtask

   initial begin
      test_reset();
      test_mgu_only();
      test_dual();
      test_backpressure();
      test_hold();
      test_null();
      test_back_to_back();
      test_stats();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_uart_cmd_dispatch
